// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU = m0, DMA = m1) to one-slave bus arbiter: fixed CPU priority with a DMA
// starvation guard. Optional slave-response timeout is enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,

  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,

  output logic [1:0]  grant,
  output logic        bus_err
);

  localparam logic [31:0] AbortRdata = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       timeout_hit;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req && m1_req) begin
          if (starve_cnt_q == 4'(STARVE_MAX)) begin
            state_d      = StGnt1;
            starve_cnt_d = 4'd0;
          end else begin
            // Below STARVE_MAX here, so the increment already saturates at the limit.
            state_d      = StGnt0;
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (m0_req) begin
          state_d = StGnt0;
        end else if (m1_req) begin
          state_d      = StGnt1;
          starve_cnt_d = 4'd0;
        end
      end
      StGnt0, StGnt1: begin
        if (s_ack || timeout_hit) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= 2'b00;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= {state_d == StGnt1, state_d == StGnt0};
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign grant = grant_q;

  always_comb begin
    s_req    = 1'b0;
    s_we     = 1'b0;
    s_addr   = 32'd0;
    s_wdata  = 32'd0;
    m0_ack   = 1'b0;
    m0_rdata = 32'd0;
    m1_ack   = 1'b0;
    m1_rdata = 32'd0;
    unique case (state_q)
      StGnt0: begin
        s_req    = 1'b1;
        s_we     = m0_we;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        m0_ack   = s_ack | timeout_hit;
        m0_rdata = timeout_hit ? AbortRdata : s_rdata;
      end
      StGnt1: begin
        s_req    = 1'b1;
        s_we     = m1_we;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        m1_ack   = s_ack | timeout_hit;
        m1_rdata = timeout_hit ? AbortRdata : s_rdata;
      end
      default: ;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [9:0] to_cnt_q, to_cnt_d;

  // Counter holds the number of stalled cycles already seen; it fires on the TIMEOUT-th one.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == StIdle) begin
      to_cnt_d = 10'd0;
    end else if (!s_ack) begin
      to_cnt_d = to_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= 10'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_hit = (state_q != StIdle) && !s_ack && (to_cnt_q == 10'(TIMEOUT - 1));
  assign bus_err     = timeout_hit;
`else
  logic unused_timeout;
  assign unused_timeout = ^(10'(TIMEOUT));
  assign timeout_hit    = 1'b0;
  assign bus_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; inputs change on the falling edge and
// outputs are sampled shortly after, away from the rising edge.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m0_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_we, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;
  logic        bus_err;

  int checks;
  int fails;
  int ack_count;

  mem_bus_arbiter #(
    .STARVE_MAX(4),
    .TIMEOUT   (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0_req  (m0_req),
    .m0_we   (m0_we),
    .m0_addr (m0_addr),
    .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata),
    .m0_ack  (m0_ack),
    .m1_req  (m1_req),
    .m1_we   (m1_we),
    .m1_addr (m1_addr),
    .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata),
    .m1_ack  (m1_ack),
    .s_req   (s_req),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .s_ack   (s_ack),
    .grant   (grant),
    .bus_err (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    ack_count = 0;
    rst_n     = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h2000_0000; m1_wdata = 32'd0;
    s_ack  = 1'b1; s_rdata = 32'h1111_1111;

    // Reset held with both requests and a stray slave ack.
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_grant", grant, 2'b00);
    check_eq("rst_s_req", s_req, 1'b0);
    check_eq("rst_m0_ack", m0_ack, 1'b0);
    check_eq("rst_m1_ack", m1_ack, 1'b0);
    check_eq("rst_bus_err", bus_err, 1'b0);
    check_eq("rst_s_addr", s_addr, 32'd0);

    // Release: CPU wins, DMA follows after the bubble.
    s_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("prio_grant_cpu", grant, 2'b01);
    check_eq("prio_s_req", s_req, 1'b1);
    s_ack = 1'b1; s_rdata = 32'h0000_0042;
    #1;
    check_eq("prio_m0_ack", m0_ack, 1'b1);
    check_eq("prio_m1_ack_quiet", m1_ack, 1'b0);
    @(negedge clk);
    m0_req = 1'b0; s_ack = 1'b0;
    #1;
    check_eq("prio_bubble_grant", grant, 2'b00);
    check_eq("prio_bubble_s_req", s_req, 1'b0);
    @(negedge clk); #1;
    check_eq("prio_grant_dma", grant, 2'b10);
    check_eq("prio_s_addr_dma", s_addr, 32'h2000_0000);
    s_ack = 1'b1; s_rdata = 32'h0000_0077;
    #1;
    check_eq("prio_m1_ack", m1_ack, 1'b1);
    check_eq("prio_m1_rdata", m1_rdata, 32'h0000_0077);
    check_eq("prio_m0_rdata_zero", m0_rdata, 32'd0);
    @(negedge clk);
    m1_req = 1'b0; s_ack = 1'b0; s_rdata = 32'd0;

    // CPU read with a combinational slave.
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000_0008;
    @(negedge clk); #1;
    check_eq("rd_grant", grant, 2'b01);
    check_eq("rd_s_addr", s_addr, 32'h1000_0008);
    check_eq("rd_s_we", s_we, 1'b0);
    s_ack = 1'b1; s_rdata = 32'h0000_00A5;
    #1;
    check_eq("rd_m0_ack", m0_ack, 1'b1);
    check_eq("rd_m0_rdata", m0_rdata, 32'h0000_00A5);
    check_eq("rd_m1_rdata_zero", m1_rdata, 32'd0);
    @(negedge clk);
    m0_req = 1'b0; s_ack = 1'b0; s_rdata = 32'd0;
    #1;
    check_eq("rd_idle_grant", grant, 2'b00);
    check_eq("rd_idle_s_addr", s_addr, 32'd0);

    // Starvation guard: four CPU grants then one DMA grant, repeating.
    m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h3000_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check_eq($sformatf("starve_grant_%0d", i), grant, (i % 5 == 4) ? 2'b10 : 2'b01);
      s_ack = 1'b1;
      #1;
      if (i % 5 == 4) check_eq($sformatf("starve_m1_ack_%0d", i), m1_ack, 1'b1);
      else            check_eq($sformatf("starve_m0_ack_%0d", i), m0_ack, 1'b1);
      @(negedge clk);
      s_ack = 1'b0;
      if (i == 9) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
      #1;
      check_eq($sformatf("starve_bubble_%0d", i), grant, 2'b00);
    end

    // DMA write with seven wait states.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h1002_0010; m1_wdata = 32'h1234_5678;
    ack_count = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 7) s_ack = 1'b1;
      #1;
      check_eq($sformatf("ws_grant_%0d", i), grant, 2'b10);
      check_eq($sformatf("ws_s_req_%0d", i), s_req, 1'b1);
      check_eq($sformatf("ws_s_we_%0d", i), s_we, 1'b1);
      check_eq($sformatf("ws_s_addr_%0d", i), s_addr, 32'h1002_0010);
      check_eq($sformatf("ws_s_wdata_%0d", i), s_wdata, 32'h1234_5678);
      check_eq($sformatf("ws_m1_ack_%0d", i), m1_ack, (i == 7) ? 1'b1 : 1'b0);
      if (m1_ack) ack_count++;
    end
    @(negedge clk);
    m1_req = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
    #1;
    if (m1_ack) ack_count++;
    check_eq("ws_ack_once", ack_count, 1);
    check_eq("ws_idle_grant", grant, 2'b00);

    // Reset mid-transfer aborts without an ack.
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'h1000_0100;
    @(negedge clk); #1;
    check_eq("rstmid_grant", grant, 2'b01);
    rst_n = 1'b0; s_ack = 1'b1;
    #1;
    check_eq("rstmid_grant_clr", grant, 2'b00);
    check_eq("rstmid_s_req", s_req, 1'b0);
    check_eq("rstmid_m0_ack", m0_ack, 1'b0);
    @(negedge clk);
    m0_req = 1'b0; s_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("rstmid_after_grant", grant, 2'b00);

`ifdef ARB_TIMEOUT_EN
    // Slave never acks: abort on the 16th stalled cycle.
    m0_req = 1'b1; m0_addr = 32'h1000_0200;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      check_eq($sformatf("to_m0_ack_%0d", i), m0_ack, (i == 15) ? 1'b1 : 1'b0);
      check_eq($sformatf("to_bus_err_%0d", i), bus_err, (i == 15) ? 1'b1 : 1'b0);
      if (i == 15) begin
        check_eq("to_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check_eq("to_s_req", s_req, 1'b1);
      end
    end
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    check_eq("to_idle_grant", grant, 2'b00);
    check_eq("to_idle_bus_err", bus_err, 1'b0);

    // Slave ack on the timeout cycle wins.
    @(negedge clk);
    m0_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        s_ack = 1'b1; s_rdata = 32'h0000_0055;
      end
      #1;
      check_eq($sformatf("torace_m0_ack_%0d", i), m0_ack, (i == 15) ? 1'b1 : 1'b0);
      check_eq($sformatf("torace_bus_err_%0d", i), bus_err, 1'b0);
    end
    check_eq("torace_m0_rdata", m0_rdata, 32'h0000_0055);
    @(negedge clk);
    m0_req = 1'b0; s_ack = 1'b0; s_rdata = 32'd0;
    #1;
    check_eq("torace_idle_grant", grant, 2'b00);
`else
    // Without the timeout a stalled transfer stays granted indefinitely.
    m0_req = 1'b1; m0_addr = 32'h1000_0200;
    repeat (40) @(negedge clk);
    #1;
    check_eq("nto_still_grant", grant, 2'b01);
    check_eq("nto_m0_ack", m0_ack, 1'b0);
    check_eq("nto_bus_err", bus_err, 1'b0);
    s_ack = 1'b1;
    #1;
    check_eq("nto_late_ack", m0_ack, 1'b1);
    @(negedge clk);
    m0_req = 1'b0; s_ack = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave arbiter for the system memory-mapped bus. It shares the single decoded slave bus between the CPU data port (master 0) and the DMA engine (master 1). It sits upstream of the address decoder, so whichever master holds the grant drives the address into the decoder and every enable it produces. Arbitration is fixed-priority for the CPU, with a starvation guard for the DMA engine, and an optional slave-response timeout.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive CPU grants while DMA is waiting, after which DMA is forced next. Range 1..15.
- TIMEOUT, 255: cycles a granted transfer may wait for s_ack before it is aborted. Range 1..1023. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  CPU transfer request; held until m0_ack.
- m0_we  in  1  CPU write (1) / read (0).
- m0_addr  in  32  CPU byte address.
- m0_wdata  in  32  CPU write data.
- m0_rdata  out  32  read data to CPU; valid when m0_ack.
- m0_ack  out  1  one-cycle completion to CPU.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same meanings for the DMA engine.
- s_req  out  1  request to the slave bus.
- s_we  out  1  muxed write enable.
- s_addr  out  32  muxed address; feeds the address decoder.
- s_wdata  out  32  muxed write data.
- s_rdata  in  32  slave read data.
- s_ack  in  1  slave completion; may be combinational in the same cycle as s_req.
- grant  out  2  one-hot owner: 01 = CPU, 10 = DMA, 00 = idle.
- bus_err  out  1  one-cycle pulse when a transfer times out.

## Operation
- FSM states: IDLE, GNT0, GNT1.
- IDLE, both requests low: stay in IDLE.
- IDLE, only one request high: go to that master's GNT state.
- IDLE, both requests high: go to GNT1 if starve_cnt == STARVE_MAX, otherwise go to GNT0.
- starve_cnt (4 bits):
  - increments, saturating at STARVE_MAX, on each IDLE->GNT0 transition taken while m1_req = 1;
  - clears on every IDLE->GNT1 transition.
- GNTx:
  - s_req = 1; s_we, s_addr and s_wdata are muxed combinationally from master x.
  - mx_ack = s_ack and mx_rdata = s_rdata, combinationally.
  - On s_ack, go to IDLE.
- Non-granted master: ack = 0, rdata = 0.
- In IDLE: s_req = 0, and s_addr, s_wdata and s_we are driven to 0.
- A master that drops req while granted is a protocol violation. The arbiter still holds s_req until s_ack, and the resulting ack is presented but ignored.
- No back-to-back grants. Every transfer returns to IDLE, giving one bubble cycle between transfers.

## Timing
- Reset values: state IDLE, grant 00, starve_cnt 0, timeout counter 0. All outputs are 0, including s_req, m0_ack, m1_ack and bus_err.
- Reset asserted mid-transfer aborts the transfer immediately. No ack is issued.
- Request latency: req sampled high in IDLE at edge N gives grant and s_req high after edge N.
- Minimum transfer: with a combinational slave, ack arrives in the first GNT cycle. That is 2 cycles from req to ack, then 1 IDLE cycle.
- Write-then-read hazard: none. Transfers are strictly serialized.
- grant is registered and changes only on FSM transitions.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A 10-bit counter clears on entry to GNT0 or GNT1 and increments each GNT cycle without s_ack.
  - When the counter reaches TIMEOUT with s_ack still low, in that cycle:
    - the granted master receives ack = 1 and rdata = 32'hDEAD_BEEF;
    - bus_err pulses 1;
    - s_req stays 1;
    - the FSM returns to IDLE on the next edge.
  - If s_ack arrives in the same cycle, it wins: normal ack, real rdata, no bus_err.
- ARB_TIMEOUT_EN undefined: no counter, bus_err tied 0, and a transfer waits indefinitely for s_ack.

## Test plan
- Reset and idle: hold rst_n = 0 with both reqs high → grant = 00, s_req = 0, all acks 0. Release → grant = 01 one edge later.
- CPU read: m0_req with addr 0x1000_0008, slave acks in the first GNT cycle with s_rdata 0x0000_00A5 → m0_ack and m0_rdata = 0x0000_00A5 in that cycle; s_addr = 0x1000_0008 while granted; IDLE on the next edge.
- Priority: both reqs asserted at the same edge → CPU is granted first and DMA is granted after the CPU ack plus one IDLE cycle.
- Starvation, with STARVE_MAX = 4, DMA held requesting and the CPU re-requesting continuously → grant sequence 01, 01, 01, 01, 10, 01...; starve_cnt clears after the DMA grant.
- Wait states: slave delays s_ack by 7 cycles on a DMA write of 0x1234_5678 to 0x1002_0010 → s_* fields stay stable for all 8 cycles; m1_ack occurs exactly once.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT = 16), slave never acks → at the 16th stalled cycle, m0_ack = 1, m0_rdata = 0xDEAD_BEEF and bus_err pulses once. In a second run, s_ack arrives at the same cycle → normal ack and no bus_err.
